// File: rtl/wb_dma_master_if.sv
// Wishbone bus bundle between the wb_dma_master initiator (master modport)
// and the memory responder (slave modport).
interface wb_dma_master_if;
   logic [15:0] wb_adr;
   logic [15:0] wb_dat_o;
   logic [15:0] wb_dat_i;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [1:0]  wb_sel;
   logic        wb_ack;

   modport master (
      output wb_adr, wb_dat_o, wb_cyc, wb_stb, wb_we, wb_sel,
      input  wb_dat_i, wb_ack
   );

   modport slave (
      input  wb_adr, wb_dat_o, wb_cyc, wb_stb, wb_we, wb_sel,
      output wb_dat_i, wb_ack
   );
endinterface

// File: rtl/wb_dma_master.sv
// Wishbone block-transfer initiator with a single host-side FIFO.
// Define WB_DMA_TIMEOUT_EN to abort a bus cycle after TIMEOUT cycles without ack.
module wb_dma_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        start,
   input  logic [15:0] cmd_adr,
   input  logic [15:0] cmd_cnt,
   input  logic        cmd_dir,
   input  logic [15:0] fifo_din,
   input  logic        fifo_push,
   output logic [15:0] fifo_dout,
   input  logic        fifo_pop,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        busy,
   output logic        done,
   output logic        error,
   wb_dma_master_if.master wb
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_REQ,
      S_GAP,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [15:0] r_adr;
   logic [15:0] r_remaining;
   logic        r_dir;
   logic        r_busy;
   logic        r_done;
   logic        r_error;
   logic [15:0] r_wb_adr;
   logic [15:0] r_wb_dat_o;
   logic        r_wb_cyc;
   logic        r_wb_stb;
   logic        r_wb_we;
   logic [1:0]  r_wb_sel;

   logic [15:0] r_mem [FIFO_DEPTH];
   logic [PW:0] r_wr_ptr;
   logic [PW:0] r_rd_ptr;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic [15:0] w_push_data;
   logic [15:0] w_head;
   logic        w_ack_req;
   logic        w_arm_go;
   logic        w_unused;

`ifdef WB_DMA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_tmo;
`endif

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   assign w_head  = r_mem[r_rd_ptr[PW-1:0]];

   // The job direction decides who owns each FIFO port: host pushes / engine pops
   // for writes, engine pushes / host pops for reads.
   assign w_ack_req   = (r_state == S_REQ) && wb.wb_ack;
   assign w_push      = !w_full && (r_dir ? fifo_push : w_ack_req);
   assign w_push_data = r_dir ? fifo_din : wb.wb_dat_i;
   assign w_pop       = !w_empty && (r_dir ? (r_state == S_ARM) : fifo_pop);
   assign w_arm_go    = (r_state == S_ARM) && (r_dir ? !w_empty : !w_full);
   assign w_unused    = cmd_adr[0] ^ (TIMEOUT > 0);

   // NOTE: storage is deliberately not reset; the pointers define validity, so
   // clearing them on reset discards the contents without a reset on every word.
   always_ff @(posedge wb_clk) begin
      if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= w_push_data;
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
      end
   end

   // NOTE: every state register below uses non-blocking assignment so all of
   // them update together from the values present before the clock edge.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state     <= S_IDLE;
         r_adr       <= '0;
         r_remaining <= '0;
         r_dir       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_wb_adr    <= '0;
         r_wb_dat_o  <= '0;
         r_wb_cyc    <= 1'b0;
         r_wb_stb    <= 1'b0;
         r_wb_we     <= 1'b0;
         r_wb_sel    <= '0;
`ifdef WB_DMA_TIMEOUT_EN
         r_tmo       <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_adr       <= {cmd_adr[15:1], 1'b0};
                  r_remaining <= cmd_cnt;
                  r_dir       <= cmd_dir;
                  r_error     <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= (cmd_cnt == 16'd0) ? S_DONE : S_ARM;
               end
            end
            S_ARM: begin
               if (w_arm_go) begin
                  if (r_dir) r_wb_dat_o <= w_head;
                  r_wb_cyc <= 1'b1;
                  r_wb_stb <= 1'b1;
                  r_wb_we  <= r_dir;
                  r_wb_sel <= 2'b11;
                  r_wb_adr <= r_adr;
`ifdef WB_DMA_TIMEOUT_EN
                  r_tmo    <= '0;
`endif
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               if (wb.wb_ack) begin
                  r_wb_stb    <= 1'b0;
                  r_adr       <= r_adr + 16'd2;
                  r_remaining <= r_remaining - 16'd1;
                  r_state     <= S_GAP;
               end
`ifdef WB_DMA_TIMEOUT_EN
               else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  r_wb_cyc <= 1'b0;
                  r_wb_stb <= 1'b0;
                  r_wb_we  <= 1'b0;
                  r_wb_sel <= '0;
                  r_error  <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
`endif
            end
            S_GAP: begin
               r_wb_cyc <= 1'b0;
               r_wb_we  <= 1'b0;
               r_wb_sel <= '0;
               r_state  <= (r_remaining == 16'd0) ? S_DONE : S_ARM;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fifo_dout   = w_head;
   assign fifo_full   = w_full;
   assign fifo_empty  = w_empty;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign wb.wb_adr   = r_wb_adr;
   assign wb.wb_dat_o = r_wb_dat_o;
   assign wb.wb_cyc   = r_wb_cyc;
   assign wb.wb_stb   = r_wb_stb;
   assign wb.wb_we    = r_wb_we;
   assign wb.wb_sel   = r_wb_sel;

endmodule
